// File: rtl/and_ctrl_seq_pkg.sv
// Shared types and helpers for the AND/invert gate operand sequencer.
// Holds the FSM state encoding, the operand beat indices and the expected
// gate function used by the optional self-check (AND_CTRL_SEQ_CHECK_EN).
package and_ctrl_seq_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam logic [1:0] BEAT_A = 2'd0;
  localparam logic [1:0] BEAT_B = 2'd1;
  localparam logic [1:0] BEAT_C = 2'd2;
  localparam logic [1:0] BEAT_D = 2'd3;

  // Expected gate output: AND of the operand LSBs, inverted when ctrl is set.
  // Only bit 0 of each operand reaches the gate, so only bit 0 is passed in.
  function automatic logic and_ctrl_exp(input logic a, input logic b,
                                        input logic c, input logic d,
                                        input logic ctrl);
    logic all_set;
    all_set = a & b & c & d;
    return ctrl ? ~all_set : all_set;
  endfunction

endpackage

// File: rtl/and_ctrl_operand_seq.sv
// Upstream sequencer for the external 4-input AND/invert gate.
// Collects operands a, b, c, d over a valid/ready stream (ctrl rides on the
// d beat), holds them on registered outputs, waits SETTLE_CYCLES, samples
// gate_out and returns it on a valid/ready result interface.
// Optional macro AND_CTRL_SEQ_CHECK_EN adds a compare of gate_out against
// the expected gate function and reports it on res_err.
module and_ctrl_operand_seq
  import and_ctrl_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       in_ctrl,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [3:0] op_c,
  output logic [3:0] op_d,
  output logic       op_ctrl,
  input  logic       gate_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_bit,
  output logic       res_ctrl,
  output logic       res_err
);

  state_t             state;
  state_t             state_next;
  logic [1:0]         beat;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_beat;
  logic               sample;
  logic               res_take;

  assign accept    = in_valid && in_ready;
  assign last_beat = (beat == BEAT_D);
  assign sample    = (state == SETTLE) && (cnt == '0);
  assign res_take  = res_valid && res_ready;

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from pre-edge values, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Next-state and in_ready decode.
  // NOTE: outputs get defaults before the case so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_next = SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) state_next = RESULT;
      end
      RESULT: begin
        if (res_ready) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Operand capture: each accepted beat lands in the register beat selects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat    <= BEAT_A;
      op_a    <= 4'h0;
      op_b    <= 4'h0;
      op_c    <= 4'h0;
      op_d    <= 4'h0;
      op_ctrl <= 1'b0;
    end else if (accept) begin
      case (beat)
        BEAT_A:  op_a <= in_data;
        BEAT_B:  op_b <= in_data;
        BEAT_C:  op_c <= in_data;
        default: begin
          op_d    <= in_data;
          op_ctrl <= in_ctrl;
        end
      endcase
      beat <= beat + 2'd1;  // 2-bit index wraps 3 -> 0 after the d beat
    end
  end

  // Settle countdown, loaded on the d beat and run down while settling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (accept && last_beat)     cnt <= CNT_W'(SETTLE_CYCLES);
    else if (state == SETTLE && !sample) cnt <= cnt - 1'b1;
  end

  // Result register: sample the gate once settled, hold until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_bit   <= 1'b0;
      res_ctrl  <= 1'b0;
    end else if (sample) begin
      res_valid <= 1'b1;
      res_bit   <= gate_out;
      res_ctrl  <= op_ctrl;
    end else if (res_take) begin
      res_valid <= 1'b0;
    end
  end

`ifdef AND_CTRL_SEQ_CHECK_EN
  // Self-check: flag a gate output that disagrees with the expected function.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           res_err <= 1'b0;
    else if (sample)   res_err <= (gate_out != and_ctrl_exp(op_a[0], op_b[0],
                                                            op_c[0], op_d[0],
                                                            op_ctrl));
    else if (res_take) res_err <= 1'b0;
  end
`else
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_and_ctrl_operand_seq.sv
// Self-checking bench for and_ctrl_operand_seq. A transaction-level model
// tracks expected outputs; a negedge process compares every cycle, and the
// directed scenarios add literal expectations.
module tb_and_ctrl_operand_seq;
  import and_ctrl_seq_pkg::*;

  parameter int SETTLE_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'h0;
  logic       in_ctrl = 1'b0;
  logic [3:0] op_a, op_b, op_c, op_d;
  logic       op_ctrl;
  logic       gate_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       res_bit;
  logic       res_ctrl;
  logic       res_err;
  bit         gate_bad = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;

  and_ctrl_operand_seq #(.SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d), .op_ctrl(op_ctrl),
    .gate_out(gate_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_bit(res_bit), .res_ctrl(res_ctrl), .res_err(res_err)
  );

  // External gate: responds to the registered operands, optionally corrupted.
  assign gate_out = and_ctrl_exp(op_a[0], op_b[0], op_c[0], op_d[0], op_ctrl) ^ gate_bad;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [3:0] m_ops [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic       m_ctrl = 1'b0;
  int         m_nbeat = 0;     // beats collected for the current set
  bit         m_busy = 1'b0;   // a full set was taken and its result not yet consumed
  int         cyc = 0;
  int         m_sample_at = 0; // edge number at which gate_out gets sampled
  bit         m_res_valid = 1'b0;
  logic       m_res_bit = 1'b0;
  logic       m_res_ctrl = 1'b0;
  logic       m_res_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ops = '{4'h0, 4'h0, 4'h0, 4'h0};
      m_ctrl = 1'b0; m_nbeat = 0; m_busy = 1'b0;
      m_res_valid = 1'b0; m_res_bit = 1'b0; m_res_ctrl = 1'b0; m_res_err = 1'b0;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (in_valid) begin
          m_ops[m_nbeat] = in_data;
          if (m_nbeat == 3) begin
            m_ctrl = in_ctrl;
            m_nbeat = 0;
            m_busy = 1'b1;
            m_sample_at = cyc + 1 + SETTLE_CYCLES;
          end else begin
            m_nbeat++;
          end
        end
      end else if (!m_res_valid) begin
        if (cyc == m_sample_at) begin
          m_res_valid = 1'b1;
          m_res_bit = (m_ops[0][0] & m_ops[1][0] & m_ops[2][0] & m_ops[3][0]) ^ m_ctrl ^ gate_bad;
          m_res_ctrl = m_ctrl;
`ifdef AND_CTRL_SEQ_CHECK_EN
          m_res_err = gate_bad;
`else
          m_res_err = 1'b0;
`endif
        end
      end else if (res_ready) begin
        m_res_valid = 1'b0;
        m_res_err = 1'b0;
        m_busy = 1'b0;
      end
    end
  end

  always @(posedge clk) if (!rst && res_valid && res_ready) hs_cnt++;

  // Per-cycle compare; res_bit/res_ctrl only matter while a result is valid.
  logic [31:0] exp_vec, act_vec;
  always @(negedge clk) begin
    exp_vec = {10'b0, !m_busy, m_ops[0], m_ops[1], m_ops[2], m_ops[3], m_ctrl,
               m_res_valid, m_res_bit & m_res_valid, m_res_ctrl & m_res_valid, m_res_err};
    act_vec = {10'b0, in_ready, op_a, op_b, op_c, op_d, op_ctrl,
               res_valid, res_bit & m_res_valid, res_ctrl & m_res_valid, res_err};
    check("cycle", act_vec, exp_vec);
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [3:0] data, input logic ctrl, input bit keep_valid);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1; in_data = data; in_ctrl = ctrl;
    while (!acc && n < 100) begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    check("beat_accept", 32'(acc), 32'(1));
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic send_set(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d, input logic ctrl, input logic early_ctrl);
    send_beat(a, early_ctrl, 1'b0);
    send_beat(b, early_ctrl, 1'b0);
    send_beat(c, early_ctrl, 1'b0);
    send_beat(d, ctrl, 1'b0);
  endtask

  // Wait for res_valid; returns edges waited.
  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("valid_timeout", 32'(res_valid), 32'(1));
  endtask

  task automatic take_result(input int delay);
    int n;
    wait_valid(n);
    repeat (delay) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #3 rst = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_ops", 32'({op_a, op_b, op_c, op_d, op_ctrl}), 32'(0));
    check("rst_res", 32'({res_bit, res_ctrl, res_err}), 32'(0));
    @(posedge clk); #1;

    // All ones, ctrl=0: latency and result
    send_set(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    check("t1_ops", 32'({op_a, op_b, op_c, op_d}), 32'h0000FFFF);
    check("t1_op_ctrl", 32'(op_ctrl), 32'(0));
    check("t1_in_ready_busy", 32'(in_ready), 32'(0));
    wait_valid(n);
    check("t1_latency", 32'(n), 32'(SETTLE_CYCLES + 1));
    check("t1_res_bit", 32'(res_bit), 32'(1));
    check("t1_res_ctrl", 32'(res_ctrl), 32'(0));
    take_result(0);

    // Same operands, ctrl=1 on d beat
    send_set(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
    wait_valid(n);
    check("t2_res_bit", 32'(res_bit), 32'(0));
    check("t2_res_ctrl", 32'(res_ctrl), 32'(1));
    take_result(1);

    // ctrl=1 on beats 0..2 only must be ignored
    send_set(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1);
    wait_valid(n);
    check("t3_res_bit", 32'(res_bit), 32'(1));
    check("t3_res_ctrl", 32'(res_ctrl), 32'(0));
    take_result(0);

    // LSB of a clear, backpressure on result for 5 cycles
    send_set(4'hE, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0);
    wait_valid(n);
    repeat (5) begin @(posedge clk); #1; end
    check("t4_hold_valid", 32'(res_valid), 32'(1));
    check("t4_hold_bit", 32'(res_bit), 32'(0));
    check("t4_hold_in_ready", 32'(in_ready), 32'(0));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("t4_valid_fall", 32'(res_valid), 32'(0));
    check("t4_in_ready_back", 32'(in_ready), 32'(1));

    // Back-to-back with in_valid held high and res_ready high
    hs_cnt = 0;
    res_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      send_beat(4'($urandom), 1'b0, 1'b1);
      send_beat(4'($urandom), 1'b0, 1'b1);
      send_beat(4'($urandom), 1'b0, 1'b1);
      send_beat(4'($urandom), 1'($urandom), t != 2);
    end
    n = 0;
    while (hs_cnt < 3 && n < 100) begin @(posedge clk); #1; n++; end
    res_ready = 1'b0;
    check("b2b_handshakes", 32'(hs_cnt), 32'(3));

    // Reset during SETTLE
    send_set(4'h3, 4'h5, 4'h7, 4'h9, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #4;
    check("rst_settle_ops", 32'({op_a, op_b, op_c, op_d, op_ctrl}), 32'(0));
    check("rst_settle_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #3 rst = 1'b0;
    #1;

    // Reset after beat 1, then a clean transaction
    send_beat(4'h0, 1'b0, 1'b0);
    send_beat(4'h0, 1'b0, 1'b0);
    pulse_reset();
    check("rst_b1_ops", 32'({op_a, op_b, op_c, op_d}), 32'(0));
    send_set(4'h1, 4'h3, 4'h5, 4'h7, 1'b0, 1'b0);
    check("post_rst_ops", 32'({op_a, op_b, op_c, op_d}), 32'h00001357);
    wait_valid(n);
    check("post_rst_res_bit", 32'(res_bit), 32'(1));
    take_result(0);

    // Corrupted gate for one transaction, then a clean one
    gate_bad = 1'b1;
    send_set(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    wait_valid(n);
    check("bad_res_bit", 32'(res_bit), 32'(0));
`ifdef AND_CTRL_SEQ_CHECK_EN
    check("bad_res_err", 32'(res_err), 32'(1));
`else
    check("bad_res_err", 32'(res_err), 32'(0));
`endif
    take_result(0);
    gate_bad = 1'b0;
    send_set(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    wait_valid(n);
    check("good_res_err", 32'(res_err), 32'(0));
    take_result(0);

    // Randomized traffic: gaps, stray res_ready, early in_ctrl noise
    for (int t = 0; t < 40; t++) begin
      for (int b = 0; b < 4; b++) begin
        int gap = $urandom_range(0, 2);
        repeat (gap) begin
          in_valid = 1'b0; in_data = 4'($urandom); in_ctrl = 1'($urandom);
          res_ready = 1'($urandom);
          @(posedge clk); #1;
        end
        res_ready = 1'b0;
        send_beat(($urandom_range(0, 3) != 0) ? 4'($urandom | 1) : 4'($urandom),
                  1'($urandom), 1'b0);
      end
      take_result($urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
